// File: rtl/axis_video_frame_src_if.sv
// axis_video_frame_src_if: AXI4-Stream video bus (TDATA/TVALID/TREADY/TUSER/TLAST)
// master drives data/valid/user/last and samples ready; slave is the mirror image.
interface axis_video_frame_src_if #(parameter int C_W = 8);
  logic [3*C_W-1:0] TDATA;
  logic             TVALID;
  logic             TREADY;
  logic             TUSER;
  logic             TLAST;
  modport master (output TDATA, TVALID, TUSER, TLAST, input TREADY);
  modport slave  (input TDATA, TVALID, TUSER, TLAST, output TREADY);
endinterface

// File: rtl/axis_video_frame_src.sv
// axis_video_frame_src: AXI4-Stream video test-pattern frame source with ap_ block handshake
// ap_clk/ap_rst: clock, sync active-high reset; ap_start/ap_ready/ap_done/ap_idle: block control;
// width/height/pattern_sel/solid_color: frame config latched on accept; m_axis_video: pixel stream;
// frame_cnt: frames completed since reset.
module axis_video_frame_src #(
  parameter int C_W   = 8,
  parameter int DIM_W = 12
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  input  logic                 ap_start,
  output logic                 ap_ready,
  output logic                 ap_done,
  output logic                 ap_idle,
  input  logic [DIM_W-1:0]     width,
  input  logic [DIM_W-1:0]     height,
  input  logic [1:0]           pattern_sel,
  input  logic [3*C_W-1:0]     solid_color,
  axis_video_frame_src_if.master m_axis_video,
  output logic [15:0]          frame_cnt
);
  localparam logic [1:0] S_IDLE = 2'd0, S_ACTIVE = 2'd1, S_DONE = 2'd2;
  logic [1:0] state_q, state_d, sel_q, sel_d;
  logic [DIM_W-1:0] x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d;
  logic [3*C_W-1:0] col_q, col_d, pix;
  logic [15:0] cnt_q, cnt_d;
  logic [C_W-1:0] xc, yc, sum;
  logic valid, fire, eol, eof;
  always_comb begin
    ap_idle = state_q == S_IDLE;
    ap_ready = ap_idle && ap_start;
    ap_done = state_q == S_DONE;
    valid = state_q == S_ACTIVE;
    fire = valid && m_axis_video.TREADY;
    eol = x_q == w_q - DIM_W'(1);
    eof = eol && y_q == h_q - DIM_W'(1);
    xc = x_q[C_W-1:0];
    yc = y_q[C_W-1:0];
    sum = xc + yc;
    // tagged pattern uses cnt_q directly: it only advances in DONE, so during ACTIVE it is the current frame index
    pix = sel_q == 2'd0 ? {yc, xc, sum} :
          sel_q == 2'd1 ? col_q :
          sel_q == 2'd2 ? {(3*C_W){x_q[3] ^ y_q[3]}} : {cnt_q[C_W-1:0], yc, xc};
    m_axis_video.TVALID = valid;
    m_axis_video.TDATA = valid ? pix : '0;
    m_axis_video.TUSER = valid && x_q == '0 && y_q == '0;
    m_axis_video.TLAST = valid && eol;
    frame_cnt = cnt_q;
    state_d = state_q;
    x_d = x_q;
    y_d = y_q;
    w_d = w_q;
    h_d = h_q;
    sel_d = sel_q;
    col_d = col_q;
    cnt_d = cnt_q;
    if (ap_ready) begin
      w_d = width;
      h_d = height;
      sel_d = pattern_sel;
      col_d = solid_color;
      x_d = '0;
      y_d = '0;
      state_d = (width != '0 && height != '0) ? S_ACTIVE : S_DONE;
    end
    if (fire) begin
      x_d = eol ? '0 : x_q + DIM_W'(1);
      y_d = eol ? y_q + DIM_W'(1) : y_q;
      state_d = eof ? S_DONE : state_q;
    end
    if (ap_done) begin
      state_d = S_IDLE;
      cnt_d = cnt_q + 16'd1;
    end
  end
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= S_IDLE;
      x_q <= '0;
      y_q <= '0;
      w_q <= '0;
      h_q <= '0;
      sel_q <= '0;
      col_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      w_q <= w_d;
      h_q <= h_d;
      sel_q <= sel_d;
      col_q <= col_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_axis_video_frame_src.sv
// tb_axis_video_frame_src: directed bench with a queue-based frame model and per-cycle stream compare
module tb_axis_video_frame_src;
  typedef struct packed {
    logic [23:0] d;
    logic u;
    logic l;
  } beat_t;
  logic ap_clk = 0, ap_rst = 1, ap_start = 0;
  logic ap_ready, ap_done, ap_idle;
  logic [11:0] width = 0, height = 0;
  logic [1:0] pattern_sel = 0;
  logic [23:0] solid_color = 0;
  logic [15:0] frame_cnt;
  int vectors = 0, miscompares = 0, m_frames = 0;
  beat_t exp_q[$], got_q[$];
  axis_video_frame_src_if #(.C_W(8)) vif();
  axis_video_frame_src #(.C_W(8), .DIM_W(12)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_idle(ap_idle), .width(width), .height(height),
    .pattern_sel(pattern_sel), .solid_color(solid_color), .m_axis_video(vif),
    .frame_cnt(frame_cnt)
  );
  always #5 ap_clk = ~ap_clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic check(string n, logic [31:0] a, logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", n, a, e);
    end
  endtask
  task automatic cyc();
    @(posedge ap_clk);
    #1;
  endtask
  function automatic logic [23:0] pix(int x, int y, int sel, logic [23:0] col, int f);
    logic [7:0] xc, yc, fc;
    xc = x[7:0];
    yc = y[7:0];
    fc = f[7:0];
    case (sel)
      0: return {yc, xc, 8'(xc + yc)};
      1: return col;
      2: return (x[3] ^ y[3]) ? 24'hFFFFFF : 24'h0;
      default: return {fc, yc, xc};
    endcase
  endfunction
  task automatic push_frame(int w, int h, int sel, logic [23:0] col, int f);
    beat_t b;
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) begin
        b.d = pix(x, y, sel, col, f);
        b.u = (x == 0 && y == 0);
        b.l = (x == w - 1);
        exp_q.push_back(b);
      end
  endtask
  always @(negedge ap_clk) begin
    if (!ap_rst && vif.TVALID) begin
      if (exp_q.size() == 0) begin
        check("spurious_beat", 32'(vif.TVALID), 32'd0);
      end else begin
        check("tdata", 32'(vif.TDATA), 32'(exp_q[0].d));
        check("tuser", 32'(vif.TUSER), 32'(exp_q[0].u));
        check("tlast", 32'(vif.TLAST), 32'(exp_q[0].l));
        if (vif.TREADY) begin
          got_q.push_back({vif.TDATA, vif.TUSER, vif.TLAST});
          void'(exp_q.pop_front());
        end
      end
    end
  end
  task automatic run_frame(int w, int h, int sel, logic [23:0] col, logic [3:0] pat,
                           int exp_done, bit mut, int mw, logic [23:0] mc);
    int c;
    bit done;
    width = w[11:0];
    height = h[11:0];
    pattern_sel = sel[1:0];
    solid_color = col;
    ap_start = 1;
    vif.TREADY = pat[0];
    #1 check("ap_ready", 32'(ap_ready), 32'd1);
    push_frame(w, h, sel, col, m_frames);
    cyc();
    ap_start = 0;
    c = 1;
    done = 0;
    while (!done && c < 20000) begin
      if (exp_q.size() != 0) check("tvalid_hold", 32'(vif.TVALID), 32'd1);
      if (ap_done) begin
        done = 1;
        check("done_empty", 32'(exp_q.size()), 32'd0);
        if (exp_done >= 0) check("done_cycle", 32'(c), 32'(exp_done));
      end else begin
        if (mut && c == 2) begin
          width = mw[11:0];
          solid_color = mc;
        end
        vif.TREADY = pat[c % 4];
        cyc();
        c++;
      end
    end
    if (!done) check("done_timeout", 32'd0, 32'd1);
    m_frames++;
    cyc();
    check("frame_cnt", 32'(frame_cnt), 32'(m_frames));
    check("idle_after", 32'(ap_idle), 32'd1);
  endtask
  logic [23:0] lit1 [8] = '{24'h000000, 24'h000101, 24'h000202, 24'h000303,
                            24'h010001, 24'h010102, 24'h010203, 24'h010304};
  initial begin
    vif.TREADY = 1;
    repeat (3) cyc();
    check("rst_idle", 32'(ap_idle), 32'd1);
    check("rst_ready", 32'(ap_ready), 32'd0);
    check("rst_done", 32'(ap_done), 32'd0);
    check("rst_tvalid", 32'(vif.TVALID), 32'd0);
    check("rst_tuser", 32'(vif.TUSER), 32'd0);
    check("rst_tlast", 32'(vif.TLAST), 32'd0);
    check("rst_tdata", 32'(vif.TDATA), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    ap_rst = 0;
    cyc();
    check("pin_ramp01", 32'(pix(1, 0, 0, 0, 0)), 32'h000101);
    check("pin_ramp31", 32'(pix(3, 1, 0, 0, 0)), 32'h010304);
    check("pin_tag02", 32'(pix(0, 2, 3, 0, 0)), 32'h000200);
    check("pin_tag_f1", 32'(pix(0, 0, 3, 0, 1)), 32'h010000);
    check("pin_chk80", 32'(pix(8, 0, 2, 0, 0)), 32'hFFFFFF);
    check("pin_chk88", 32'(pix(8, 8, 2, 0, 0)), 32'h000000);
    // 4x2 ramp, full throughput
    got_q.delete();
    run_frame(4, 2, 0, 0, 4'hF, 9, 0, 0, 0);
    check("t1_beats", 32'(got_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      check("t1_lit_data", 32'(got_q[i].d), 32'(lit1[i]));
      check("t1_lit_user", 32'(got_q[i].u), 32'(i == 0));
      check("t1_lit_last", 32'(got_q[i].l), 32'(i == 3 || i == 7));
    end
    // same frame under backpressure 1,0,0,1
    run_frame(4, 2, 0, 0, 4'b1001, -1, 0, 0, 0);
    // zero-size frame
    run_frame(0, 5, 0, 0, 4'hF, 1, 0, 0, 0);
    // tagged, width 1, two frames with ap_start held high
    ap_rst = 1;
    cyc();
    ap_rst = 0;
    m_frames = 0;
    cyc();
    check("t4_cnt0", 32'(frame_cnt), 32'd0);
    got_q.delete();
    width = 12'd1;
    height = 12'd3;
    pattern_sel = 2'd3;
    vif.TREADY = 1;
    push_frame(1, 3, 3, 0, 0);
    push_frame(1, 3, 3, 0, 1);
    ap_start = 1;
    #1;
    for (int c = 0; c < 10; c++) begin
      check("t4_ready", 32'(ap_ready), 32'(c == 0 || c == 5));
      check("t4_done", 32'(ap_done), 32'(c == 4 || c == 9));
      if (c == 4 || c == 5) check("t4_gap_tvalid", 32'(vif.TVALID), 32'd0);
      if (c == 6) check("t4_f2_tuser", 32'(vif.TUSER), 32'd1);
      if (c == 9) ap_start = 0;
      cyc();
    end
    m_frames = 2;
    check("t4_cnt2", 32'(frame_cnt), 32'd2);
    check("t4_beats", 32'(got_q.size()), 32'd6);
    if (got_q.size() == 6) begin
      check("t4_f1b1", 32'(got_q[1].d), 32'h000100);
      check("t4_f1b2", 32'(got_q[2].d), 32'h000200);
      check("t4_f2b0", 32'(got_q[3].d), 32'h010000);
      check("t4_f1last", 32'(got_q[1].l), 32'd1);
    end
    // reset on the third beat of a 640x480 frame
    width = 12'd640;
    height = 12'd480;
    pattern_sel = 2'd0;
    push_frame(3, 1, 0, 0, m_frames);
    ap_start = 1;
    cyc();
    ap_start = 0;
    cyc();
    cyc();
    check("t5_beat2", 32'(vif.TDATA), 32'h000202);
    ap_rst = 1;
    cyc();
    check("t5_tvalid", 32'(vif.TVALID), 32'd0);
    check("t5_cnt", 32'(frame_cnt), 32'd0);
    check("t5_done", 32'(ap_done), 32'd0);
    ap_rst = 0;
    exp_q.delete();
    m_frames = 0;
    for (int c = 0; c < 4; c++) begin
      check("t5_no_done", 32'(ap_done), 32'd0);
      cyc();
    end
    run_frame(3, 2, 0, 0, 4'hF, 7, 0, 0, 0);
    // solid colour with mid-frame config change
    run_frame(5, 2, 1, 24'hABCDEF, 4'hF, 11, 1, 3, 24'h123456);
    run_frame(3, 2, 1, 24'h123456, 4'hF, 7, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/axis_video_frame_src.md
Name: axis_video_frame_src

Overview:
- AXI4-Stream video transmitter. Generates complete frames of a selectable test pattern on the same stream protocol that the VIP input stage (AXIvideo2Mat) receives.
- Used as the stimulus-side counterpart feeding the dataflow chain in simulation, and as an on-chip pattern source for bring-up.
- Frame start is marked with TUSER and every line end with TLAST.
- Control uses the ap_start/ap_done/ap_idle/ap_ready block-level handshake, so it chains like the other dataflow processes.

Parameters:
- C_W, 8, bits per colour channel; TDATA width is 3*C_W.
- DIM_W, 12, width of the width/height inputs and of the x/y counters.

Ports:
- ap_clk  in  1  clock; all logic on rising edge.
- ap_rst  in  1  synchronous, active-high reset.
- ap_start  in  1  request one frame.
- ap_ready  out  1  one-cycle pulse: configuration latched, start accepted.
- ap_done  out  1  one-cycle pulse after the last beat of the frame.
- ap_idle  out  1  high while in IDLE.
- width  in  DIM_W  pixels per line; sampled when start is accepted.
- height  in  DIM_W  lines per frame; sampled when start is accepted.
- pattern_sel  in  2  0=ramp, 1=solid, 2=checker, 3=tagged; sampled when start is accepted.
- solid_color  in  3*C_W  pixel value for pattern 1; sampled when start is accepted.
- m_axis_video_TDATA  out  3*C_W  pixel.
- m_axis_video_TVALID  out  1  beat valid.
- m_axis_video_TREADY  in  1  sink ready.
- m_axis_video_TUSER  out  1  start of frame (pixel 0,0).
- m_axis_video_TLAST  out  1  last pixel of line.
- frame_cnt  out  16  frames completed since reset; wraps 0xFFFF->0.

Behaviour:
- Clock and reset: one clock, ap_clk. ap_rst is synchronous, active-high. At an edge with ap_rst=1:
  - state=IDLE, ap_idle=1.
  - ap_ready=0, ap_done=0, TVALID=0, TUSER=0, TLAST=0, TDATA=0.
  - x=0, y=0, frame_cnt=0.
- Reset mid-frame: TVALID is 0 from the cycle after the reset edge. No completion pulse; frame_cnt is unchanged by the aborted frame (it resets to 0).
- States: IDLE, ACTIVE, DONE.
- IDLE:
  - ap_idle=1, TVALID=0.
  - If ap_start=1: ap_ready=1 combinationally in that cycle, and the configuration is latched at the edge.
  - If latched width!=0 and height!=0, go to ACTIVE; otherwise go to DONE, emitting no beats.
- ACTIVE:
  - TVALID=1 from the first ACTIVE cycle. Latency from the ap_start cycle to first TVALID is 1 cycle.
  - A beat transfers when TVALID&TREADY. TDATA, TUSER and TLAST hold stable while TVALID&!TREADY.
  - TVALID never deasserts inside a frame; back-to-back beats run at one per cycle when TREADY=1.
  - TUSER=1 only when x=0 and y=0.
  - TLAST=1 when x=width-1.
  - On a transfer: if x=width-1, then x<=0 and y<=y+1; else x<=x+1.
  - On transfer of (width-1, height-1): go to DONE; TVALID=0 the next cycle.
- DONE:
  - Single cycle: ap_done=1, frame_cnt<=frame_cnt+1 (including zero-size frames).
  - Then IDLE. ap_start held high is not accepted in DONE; it is accepted the following IDLE cycle.
  - Minimum frame-to-frame gap: 2 idle cycles between the last beat and the next TUSER beat.
- Config changes: inputs changed outside IDLE acceptance have no effect on the frame in flight.
- Patterns (xc = x[C_W-1:0], yc = y[C_W-1:0]; channel order {ch2,ch1,ch0} MSB first; all sums modulo 2^C_W):
  - 0 ramp: {yc, xc, xc+yc}.
  - 1 solid: solid_color.
  - 2 checker: all-ones if x[3]^y[3], else all-zeros.
  - 3 tagged: {frame_cnt[C_W-1:0], yc, xc}. frame_cnt is the value at frame start, i.e. the index of the current frame.
- Width 1: TUSER and TLAST are both 1 on the first beat; every beat has TLAST=1.
- Height 1: a single line, then DONE.
- Max dims: 2^DIM_W-1; counters must not overflow at this maximum.

Test Plan:
- Reset then ap_start, width=4, height=2, pattern 0, TREADY=1 -> ap_ready at cycle 0; 8 consecutive beats from cycle 1.
  - TDATA = 0x000000, 0x000101, 0x000202, 0x000303, 0x010001, 0x010102, 0x010203, 0x010304.
  - TUSER on beat 0 only; TLAST on beats 3 and 7.
  - ap_done at cycle 9; frame_cnt=1.
- Same frame with TREADY toggling 1,0,0,1 repeating -> identical 8-beat sequence; TDATA/TUSER/TLAST stable on every stalled cycle; TVALID stays 1 until the final transfer.
- width=0, height=5, ap_start -> ap_ready, then ap_done the next cycle; zero TVALID cycles; frame_cnt increments.
- Pattern 3, width=1, height=3, two frames with ap_start held high -> first frame: beats 0x000000, 0x000100, 0x000200, each with TLAST=1.
  - Second frame tag byte = 0x01.
  - TUSER of frame 2 arrives 2 idle cycles after the last beat of frame 1.
- ap_rst asserted on the 3rd beat of a 640x480 frame -> TVALID=0 the next cycle; frame_cnt=0; no ap_done.
  - A new ap_start then begins with TUSER at (0,0).
- Pattern 1 with solid_color=0xABCDEF; change width and solid_color mid-frame -> the frame keeps the original width and 0xABCDEF; the next frame uses the new values.
